// File: rtl/dsram_responder.sv
// Data-side SRAM responder: byte-masked write / word read with a registered read port.
// Optional wait states are compiled in with `define DSRAM_WAIT_EN (WAIT_CYC then honoured).
module dsram_responder #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_ok,
    output logic        stallreq
);

`ifdef DSRAM_WAIT_EN
    localparam int EFF_WAIT = WAIT_CYC;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
`else
    localparam int EFF_WAIT = 0;
    typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;
`endif

    state_t            state_q, state_d;
    logic [31:0]       mem [0:(1 << ADDR_W) - 1];
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] in_idx;
    logic              acc_fire;
    logic [ADDR_W-1:0] acc_idx;
    logic [3:0]        acc_wen;
    logic [31:0]       acc_wdata;
    logic              stall;
    logic              unused_addr;

    assign in_idx      = data_sram_addr[ADDR_W+1:2];
    assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

`ifdef DSRAM_WAIT_EN
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [3:0]        wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        acc_fire  = 1'b0;
        acc_idx   = in_idx;
        acc_wen   = data_sram_wen;
        acc_wdata = data_sram_wdata;
        stall     = 1'b0;
        case (state_q)
            WAIT: begin
                // Bus inputs are ignored here; the latched request drives the access.
                acc_idx   = idx_q;
                acc_wen   = wen_q;
                acc_wdata = wdata_q;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                    stall = 1'b1;
                end else begin
                    acc_fire = 1'b1;
                    state_d  = DONE;
                end
            end
            default: begin
                if (data_sram_en) begin
                    idx_d   = in_idx;
                    wen_d   = data_sram_wen;
                    wdata_d = data_sram_wdata;
                    if (EFF_WAIT == 0) begin
                        acc_fire = 1'b1;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = 4'(EFF_WAIT - 1);
                        stall   = 1'b1;
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wen_q   <= 4'd0;
            wdata_q <= 32'h0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
        end
    end
`else
    always_comb begin
        acc_fire  = data_sram_en;
        acc_idx   = in_idx;
        acc_wen   = data_sram_wen;
        acc_wdata = data_sram_wdata;
        stall     = 1'b0;
        state_d   = data_sram_en ? DONE : IDLE;
    end
`endif

    always_comb begin
        rdata_d = rdata_q;
        if (acc_fire) begin
            rdata_d = mem[acc_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is never reset; writes are blocked while reset is held so contents survive it.
    always_ff @(posedge clk) begin
        if (acc_fire && rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wen[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign data_ok         = (state_q == DONE);
    assign stallreq        = stall;

endmodule

// File: tb/tb_dsram_responder.sv
// Self-checking bench for dsram_responder: table-driven accesses checked through a scoreboard,
// plus reset sequences. Wait-state sequences are compiled when DSRAM_WAIT_EN is defined.
module tb_dsram_responder;

`ifdef DSRAM_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  wen = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        data_ok;
    logic        stallreq;

    dsram_responder #(.ADDR_W(10), .WAIT_CYC(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .data_ok         (data_ok),
        .stallreq        (stallreq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] exp;
        bit          chk;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        bit          chk;
    } vec_t;
    vec_t tbl [15];

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_exp = 32'h0;
    bit          last_chk = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every data_ok must match the oldest outstanding request, on its due cycle.
    always @(negedge clk) begin
        if (data_ok) begin
            if (sb.size() == 0) begin
                check("spurious_data_ok", 32'(data_ok), 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("data_ok_latency", 32'(cyc), 32'(e.due));
                if (e.chk) check("rdata", rdata, e.exp);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            check("data_ok_missing", 32'(data_ok), 32'd1);
            void'(sb.pop_front());
        end
    end

    task automatic issue(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp, input bit chk);
        sb_t e;
        @(negedge clk);
        en = 1'b1; wen = w; addr = a; wdata = d;
        e.due = cyc + 1 + W; e.exp = exp; e.chk = chk;
        sb.push_back(e);
        last_exp = exp; last_chk = chk;
        #1 check("stall_req_cycle", 32'(stallreq), 32'(W > 0));
        for (int j = 1; j <= W; j++) begin
            @(negedge clk);
            en = 1'($urandom_range(0, 1)); wen = 4'($urandom); addr = $urandom; wdata = $urandom;
            #1 check("stall_wait", 32'(stallreq), 32'(j < W));
        end
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        #1 check("stall_idle", 32'(stallreq), 32'd0);
        if (last_chk) check("rdata_hold", rdata, last_exp);
    endtask

    initial begin
        tbl[0]  = '{4'hF, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         1'b0};
        tbl[1]  = '{4'h0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b1};
        tbl[2]  = '{4'hF, 32'h0000_0080, 32'h1122_3344, 32'h0,         1'b0};
        tbl[3]  = '{4'h4, 32'h0000_0082, 32'hAAAA_AAAA, 32'h1122_3344, 1'b1};
        tbl[4]  = '{4'h0, 32'h0000_0080, 32'h0,         32'h11AA_3344, 1'b1};
        tbl[5]  = '{4'hF, 32'h0000_1004, 32'h1234_5678, 32'h0,         1'b0};
        tbl[6]  = '{4'h0, 32'h0040_1004, 32'h0,         32'h1234_5678, 1'b1};
        tbl[7]  = '{4'h3, 32'h0040_1006, 32'h0000_CAFE, 32'h1234_5678, 1'b1};
        tbl[8]  = '{4'h0, 32'h0000_1007, 32'h0,         32'h1234_CAFE, 1'b1};
        tbl[9]  = '{4'h9, 32'h0000_0040, 32'h5500_0066, 32'hDEAD_BEEF, 1'b1};
        tbl[10] = '{4'h0, 32'h0000_0041, 32'h0,         32'h55AD_BE66, 1'b1};
        tbl[11] = '{4'h8, 32'h0000_0083, 32'h9999_9999, 32'h11AA_3344, 1'b1};
        tbl[12] = '{4'h0, 32'h0000_0080, 32'h0,         32'h99AA_3344, 1'b1};
        tbl[13] = '{4'hF, 32'h0000_0FFC, 32'h0BAD_F00D, 32'h0,         1'b0};
        tbl[14] = '{4'h0, 32'hFFFF_FFFC, 32'h0,         32'h0BAD_F00D, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check("reset_rdata", rdata, 32'h0);
        check("reset_data_ok", 32'(data_ok), 32'd0);
        check("reset_stall", 32'(stallreq), 32'd0);
        rst_n = 1'b1;
        repeat (5) idle();

        for (int i = 0; i < 15; i++) begin
            issue(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].exp, tbl[i].chk);
            if (i == 6) idle();
        end
        repeat (3) idle();

        // Reset between accesses: rdata clears, memory keeps its contents.
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("rst_rdata_clear", rdata, 32'h0);
        check("rst_data_ok", 32'(data_ok), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = 32'h0; last_chk = 1'b1;
        idle();
        issue(4'h0, 32'h0000_0080, 32'h0, 32'h99AA_3344, 1'b1);
        issue(4'h0, 32'h0000_0040, 32'h0, 32'h55AD_BE66, 1'b1);
        idle();

`ifdef DSRAM_WAIT_EN
        // Reset during the first wait cycle drops the pending write.
        @(negedge clk);
        en = 1'b1; wen = 4'hF; addr = 32'h0000_0080; wdata = 32'h0102_0304;
        #1 check("midwait_req_stall", 32'(stallreq), 32'd1);
        @(negedge clk);
        en = 1'b0; wen = 4'h0;
        #1 check("midwait_in_wait_stall", 32'(stallreq), 32'd1);
        rst_n = 1'b0;
        #1 check("midwait_rst_stall", 32'(stallreq), 32'd0);
        check("midwait_rst_data_ok", 32'(data_ok), 32'd0);
        @(negedge clk);
        #1 check("midwait_rst_data_ok2", 32'(data_ok), 32'd0);
        rst_n = 1'b1;
        last_exp = 32'h0; last_chk = 1'b1;
        idle();
        issue(4'h0, 32'h0000_0080, 32'h0, 32'h99AA_3344, 1'b1);
        idle();
`endif

        repeat (3) idle();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
